// File: rtl/approx_mult4.sv
// ---------------------------------------------------------------------------
// approx_mult4 -- registered 4x4 unsigned approximate multiplier
//
// The product is computed from the AND partial products p[i][j] = A[i] & B[j].
// Column 0 is p[0][0]. Column 1 is the OR of its two partial products, and it
// gives no carry into column 2. Columns 2..6 are summed exactly. The result is
// A*B, except that A[1:0] == B[1:0] == 3 gives A*B - 2. The largest result is
// 223 (15 x 15).
//
// Columns 2..6 are reduced to two rows with half/full adders. The final
// carry-propagate adder is chosen by ADDER_SEL:
//   0 ripple-carry, 1 carry-save layer then ripple, 2 carry-select,
//   3 conditional-sum. Any other value builds the ripple-carry adder.
// Every choice gives the same bits.
//
// Build option: define the macro CLK_GATE_EN to clock the Y register through a
// latch-based clock gate enabled by (en | rst). Without the macro, en is a
// synchronous load-enable on a free-running register. y_valid always runs on
// clk. Both builds show the same behaviour at each clock cycle.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset (has priority over en)
//   en       in   1  operand valid / capture enable
//   A        in   4  unsigned multiplicand
//   B        in   4  unsigned multiplier
//   Y        out  8  registered approximate product (holds while en = 0)
//   y_valid  out  1  high for the cycle after a capture
// ---------------------------------------------------------------------------
module approx_mult4 #(
    parameter int ADDER_SEL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] Y,
    output logic       y_valid
);

    // Half adder: {carry, sum}
    function automatic logic [1:0] ha(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    // Full adder: {carry, sum}
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    function automatic logic [5:0] rca5(input logic [4:0] a, input logic [4:0] b,
                                        input logic cin);
        logic       c;
        logic [5:0] r;
        c = cin;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[5] = c;
        return r;
    endfunction

    function automatic logic [3:0] rca3(input logic [2:0] a, input logic [2:0] b,
                                        input logic cin);
        logic       c;
        logic [3:0] r;
        c = cin;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[3] = c;
        return r;
    endfunction

    function automatic logic [2:0] rca2(input logic [1:0] a, input logic [1:0] b,
                                        input logic cin);
        logic       c;
        logic [2:0] r;
        c = cin;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[2] = c;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Partial products, pp[i][j] = A[i] & B[j]
    // ------------------------------------------------------------------
    logic [3:0][3:0] pp;

    // NOTE: every signal written in always_comb is assigned on every path
    // (here by the unconditional loop), so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp[i][j] = A[i] & B[j];
            end
        end
    end

    // Approximate column 1: OR instead of add, so no carry into column 2
    logic c1_or;
    assign c1_or = pp[1][0] | pp[0][1];

    // ------------------------------------------------------------------
    // Reduce columns 2..6 to two rows. Bit k of row_x and row_y has weight
    // 2^k in S, which is column k+2 of the product.
    // Column heights before reduction are 3,4,3,2,1.
    // ------------------------------------------------------------------
    logic [1:0] k0_ha, k1_fa, k1_ha, k2_fa, k2_ha, k3_fa;
    logic [4:0] row_x, row_y;

    assign k0_ha = ha(pp[2][0], pp[1][1]);
    assign k1_fa = fa(pp[3][0], pp[2][1], pp[1][2]);
    assign k1_ha = ha(pp[0][3], k0_ha[1]);
    assign k2_fa = fa(pp[3][1], pp[2][2], pp[1][3]);
    assign k2_ha = ha(k1_fa[1], k1_ha[1]);
    assign k3_fa = fa(pp[3][2], pp[2][3], k2_fa[1]);

    assign row_x = {pp[3][3], k3_fa[0], k2_fa[0], k1_fa[0], k0_ha[0]};
    assign row_y = {k3_fa[1], k2_ha[1], k2_ha[0], k1_ha[0], pp[0][2]};

    // ------------------------------------------------------------------
    // Final carry-propagate adder: s_sum = row_x + row_y (at most 55)
    // ------------------------------------------------------------------
    logic [5:0] s_sum;

    if (ADDER_SEL == 1) begin : g_csa
        // One more carry-save layer, then a ripple adder for sum + carry row
        logic [4:0] csa_s, csa_c;
        logic [5:0] rip;
        assign csa_s = row_x ^ row_y;
        assign csa_c = row_x & row_y;
        assign rip   = rca5(csa_s, {csa_c[3:0], 1'b0}, 1'b0);
        // csa_c[4] and rip[5] can never both be set because the sum is at most 55
        assign s_sum = {rip[5] | csa_c[4], rip[4:0]};
    end else if (ADDER_SEL == 2) begin : g_csel
        // Low 3 bits ripple; the high 2 bits are precomputed for both carries
        logic [3:0] lo;
        logic [2:0] hi0, hi1;
        assign lo    = rca3(row_x[2:0], row_y[2:0], 1'b0);
        assign hi0   = rca2(row_x[4:3], row_y[4:3], 1'b0);
        assign hi1   = rca2(row_x[4:3], row_y[4:3], 1'b1);
        assign s_sum = {(lo[3] ? hi1 : hi0), lo[2:0]};
    end else if (ADDER_SEL == 3) begin : g_cond
        // Conditional sum. Each bit has a sum and a carry for carry-in 0 and
        // for carry-in 1. Blocks of 2 and then 4 are merged by muxes. Bit 0
        // only needs the carry-in 0 case.
        logic [4:0] s0, c0;
        logic [4:1] s1, c1;
        logic [1:0] a_sum, b0_sum, b1_sum;
        logic       a_co, b0_co, b1_co, lo4_co;
        assign s0 = row_x ^ row_y;
        assign c0 = row_x & row_y;
        assign s1 = ~(row_x[4:1] ^ row_y[4:1]);
        assign c1 = row_x[4:1] | row_y[4:1];
        // block [1:0], carry-in 0
        assign a_sum  = {(c0[0] ? s1[1] : s0[1]), s0[0]};
        assign a_co   = c0[0] ? c1[1] : c0[1];
        // block [3:2], both carry-ins
        assign b0_sum = {(c0[2] ? s1[3] : s0[3]), s0[2]};
        assign b1_sum = {(c1[2] ? s1[3] : s0[3]), s1[2]};
        assign b0_co  = c0[2] ? c1[3] : c0[3];
        assign b1_co  = c1[2] ? c1[3] : c0[3];
        // merge into block [3:0], then resolve bit 4
        assign lo4_co = a_co ? b1_co : b0_co;
        assign s_sum  = {(lo4_co ? c1[4] : c0[4]),
                         (lo4_co ? s1[4] : s0[4]),
                         (a_co ? b1_sum : b0_sum),
                         a_sum};
    end else begin : g_rca
        assign s_sum = rca5(row_x, row_y, 1'b0);
    end

    // R = 4*S + 2*c1 + p00; S is at most 55, so R fits in 8 bits
    logic [7:0] r_comb;
    assign r_comb = {s_sum, c1_or, pp[0][0]};

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [7:0] y_d, y_q;
    logic       y_valid_d, y_valid_q;

    always_comb begin
        y_d       = y_q;
        y_valid_d = en;
        if (en) begin
            y_d = r_comb;
        end
    end

`ifdef CLK_GATE_EN
    // Integrated clock gate. The enable is captured while clk is low, so gclk
    // cannot glitch. rst is part of the enable so that the clear still reaches
    // the gated register.
    logic gate_en_lat;
    logic gclk;

    always_latch begin
        if (!clk) begin
            gate_en_lat <= en | rst;
        end
    end

    assign gclk = clk & gate_en_lat;

    always_ff @(posedge gclk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end
`else
    // NOTE: sequential state is assigned with non-blocking (<=) so that every
    // flop samples values from before the edge, whatever the evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= y_valid_d;
        end
    end

    assign Y       = y_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_approx_mult4.sv
// ---------------------------------------------------------------------------
// tb_approx_mult4 -- self-checking bench for approx_mult4.
// Five instances (ADDER_SEL 0, 1, 2, 3, 7) share one set of stimulus. Each
// instance is checked against a reference model that applies the arithmetic
// rule: A*B, less 2 when both low operand bit pairs are 3.
// ---------------------------------------------------------------------------
module tb_approx_mult4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;

    logic [7:0] y_out [5];
    logic       v_out [5];

    int sel_ids [5] = '{0, 1, 2, 3, 7};

    int errors = 0;
    int checks = 0;

    // Scoreboard state: what every instance should show after the last edge
    logic [7:0] exp_y;
    logic       exp_v;

    always #5 clk = ~clk;

    approx_mult4 #(.ADDER_SEL(0)) u_sel0 (.clk(clk), .rst(rst), .en(en), .A(a), .B(b),
                                          .Y(y_out[0]), .y_valid(v_out[0]));
    approx_mult4 #(.ADDER_SEL(1)) u_sel1 (.clk(clk), .rst(rst), .en(en), .A(a), .B(b),
                                          .Y(y_out[1]), .y_valid(v_out[1]));
    approx_mult4 #(.ADDER_SEL(2)) u_sel2 (.clk(clk), .rst(rst), .en(en), .A(a), .B(b),
                                          .Y(y_out[2]), .y_valid(v_out[2]));
    approx_mult4 #(.ADDER_SEL(3)) u_sel3 (.clk(clk), .rst(rst), .en(en), .A(a), .B(b),
                                          .Y(y_out[3]), .y_valid(v_out[3]));
    approx_mult4 #(.ADDER_SEL(7)) u_sel7 (.clk(clk), .rst(rst), .en(en), .A(a), .B(b),
                                          .Y(y_out[4]), .y_valid(v_out[4]));

    // Reference: exact product, minus 2 when both low bit pairs are 3
    function automatic logic [7:0] model(input int ma, input int mb);
        int p;
        p = ma * mb;
        if ((ma % 4) == 3 && (mb % 4) == 3) begin
            p = p - 2;
        end
        return 8'(p);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ey, input logic ev);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s Y sel%0d", tag, sel_ids[k]), y_out[k], ey);
            check($sformatf("%s y_valid sel%0d", tag, sel_ids[k]), {7'd0, v_out[k]}, {7'd0, ev});
        end
    endtask

    // Drive inputs on the falling edge, then let one rising edge pass and
    // update the scoreboard. Outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic e, input logic [3:0] sa, input logic [3:0] sb);
        @(negedge clk);
        rst = r;
        en  = e;
        a   = sa;
        b   = sb;
        @(posedge clk);
        #1;
        if (r) begin
            exp_y = 8'd0;
            exp_v = 1'b0;
        end else if (e) begin
            exp_y = model(int'(sa), int'(sb));
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp_y;
        logic       exp_v;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        exp_y = 8'd0;
        exp_v = 1'b0;

        // Directed table: reset, exact products, approximate products, hold
        tbl[0]  = '{1'b1, 1'b1, 4'd15, 4'd15, 8'd0,   1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'd15, 4'd15, 8'd0,   1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'd15, 4'd15, 8'd223, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 4'd5,  4'd6,  8'd30,  1'b1};
        tbl[4]  = '{1'b0, 1'b1, 4'd0,  4'd9,  8'd0,   1'b1};
        tbl[5]  = '{1'b0, 1'b1, 4'd12, 4'd15, 8'd180, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 4'd3,  4'd3,  8'd7,   1'b1};
        tbl[7]  = '{1'b0, 1'b1, 4'd7,  4'd11, 8'd75,  1'b1};
        tbl[8]  = '{1'b0, 1'b1, 4'd15, 4'd15, 8'd223, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 4'd9,  4'd9,  8'd81,  1'b1};
        tbl[10] = '{1'b0, 1'b0, 4'd4,  4'd2,  8'd81,  1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'd7,  4'd7,  8'd81,  1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'd15, 4'd1,  8'd81,  1'b0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].a, tbl[i].b);
            check_all($sformatf("tbl[%0d]", i), tbl[i].exp_y, tbl[i].exp_v);
        end

        // Every operand pair on every adder variant
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                step(1'b0, 1'b1, 4'(ai), 4'(bi));
                check_all($sformatf("exh a=%0d b=%0d", ai, bi), exp_y, exp_v);
            end
        end

        // Reset in the middle of a back-to-back stream (5th pair)
        for (int i = 0; i < 10; i++) begin
            step((i == 4), 1'b1, 4'($urandom), 4'($urandom));
            check_all($sformatf("midrst[%0d]", i), exp_y, exp_v);
        end

        // Random enables, operands and occasional resets against the scoreboard
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom), 4'($urandom));
            check_all($sformatf("rand[%0d]", i), exp_y, exp_v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
